// File: rtl/aurora8b10b_tx_frame_gen.sv
// AXI4-Stream frame source feeding the Aurora 8B10B TX user interface for link bring-up and loopback.
// Optional macro TX_PRBS_EN: PRBS-31 payload in place of the {frame index, word index} counter.
module aurora8b10b_tx_frame_gen #(
  parameter int GAP_CYCLES = 4,
  parameter int LEN_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_channel_up,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic [LEN_W-1:0] i_frame_num,
  input  logic             i_stop,
  output logic [31:0]      m_axi_tx_tdata,
  output logic [3:0]       m_axi_tx_tkeep,
  output logic             m_axi_tx_tlast,
  output logic             m_axi_tx_tvalid,
  input  logic             m_axi_tx_tready,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_frame_cnt
);

  typedef enum logic [2:0] {IDLE, WAIT_UP, SEND, GAP, DONE} state_e;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  function automatic logic [3:0] last_keep(input logic [1:0] rem);
    case (rem)
      2'b01:   return 4'b1000;
      2'b10:   return 4'b1100;
      2'b11:   return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

`ifdef TX_PRBS_EN
  localparam logic [31:0] PRBS_SEED = 32'h7FFF_FFFF;

  // Advance x^31 + x^28 + 1 by 32 bits; the result is the 32 freshly generated bits.
  function automatic logic [31:0] prbs31_next32(input logic [31:0] s_in);
    logic [31:0] s;
    s = s_in;
    for (int i = 0; i < 32; i++) s = {s[30:0], s[30] ^ s[27]};
    return s;
  endfunction
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] last_idx_q, last_idx_d;
  logic [3:0]       keep_last_q, keep_last_d;
  logic [LEN_W-1:0] num_q, num_d;
  logic [LEN_W-1:0] run_idx_q, run_idx_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [15:0]      gap_q, gap_d;
  logic             stop_q, stop_d;
  logic [31:0]      tdata_q, tdata_d;
  logic [3:0]       tkeep_q, tkeep_d;
  logic             tlast_q, tlast_d;
  logic             tvalid_q, tvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic             load_word;
  logic             stop_any;

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    keep_last_d = keep_last_q;
    num_d       = num_q;
    run_idx_d   = run_idx_q;
    word_idx_d  = word_idx_q;
    gap_d       = gap_q;
    stop_d      = stop_q | (i_stop & (state_q != IDLE));
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    frame_cnt_d = frame_cnt_q;
    load_word   = 1'b0;
    stop_any    = stop_q | i_stop;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (i_start && (i_frame_len != '0)) begin
          last_idx_d  = (i_frame_len - LEN_W'(1)) >> 2;
          keep_last_d = last_keep(i_frame_len[1:0]);
          num_d       = i_frame_num;
          run_idx_d   = '0;
          state_d     = WAIT_UP;
        end
      end
      WAIT_UP: begin
        if (stop_any) begin
          state_d = DONE;
        end else if (i_channel_up) begin
          state_d    = SEND;
          word_idx_d = '0;
          load_word  = 1'b1;
          tvalid_d   = 1'b1;
        end
      end
      SEND: begin
        if (tvalid_q && m_axi_tx_tready && tlast_q) begin
          // Frame fully accepted; a drop on this same cycle still counts it.
          frame_cnt_d = frame_cnt_q + 32'd1;
          run_idx_d   = run_idx_q + LEN_W'(1);
          tvalid_d    = 1'b0;
          if (((num_q != '0) && (run_idx_d == num_q)) || stop_any) begin
            state_d = DONE;
          end else if (!i_channel_up) begin
            state_d = WAIT_UP;
          end else if (GAP_CYCLES == 0) begin
            word_idx_d = '0;
            load_word  = 1'b1;
            tvalid_d   = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else if (!i_channel_up) begin
          state_d  = WAIT_UP;
          tvalid_d = 1'b0;
        end else if (tvalid_q && m_axi_tx_tready) begin
          word_idx_d = word_idx_q + LEN_W'(1);
          load_word  = 1'b1;
        end
      end
      GAP: begin
        if (stop_any) begin
          state_d = DONE;
        end else if (!i_channel_up) begin
          state_d = WAIT_UP;
        end else if (gap_q == GAP_LAST) begin
          state_d    = SEND;
          word_idx_d = '0;
          load_word  = 1'b1;
          tvalid_d   = 1'b1;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (load_word) begin
      tlast_d = (word_idx_d == last_idx_q);
      tkeep_d = tlast_d ? keep_last_q : 4'b1111;
`ifdef TX_PRBS_EN
      tdata_d = (word_idx_d == '0) ? prbs31_next32(PRBS_SEED) : prbs31_next32(tdata_q);
`else
      tdata_d = {16'(run_idx_d), 16'(word_idx_d)};
`endif
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_idx_q  <= '0;
      keep_last_q <= '0;
      num_q       <= '0;
      run_idx_q   <= '0;
      word_idx_q  <= '0;
      gap_q       <= '0;
      stop_q      <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_idx_q  <= last_idx_d;
      keep_last_q <= keep_last_d;
      num_q       <= num_d;
      run_idx_q   <= run_idx_d;
      word_idx_q  <= word_idx_d;
      gap_q       <= gap_d;
      stop_q      <= stop_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_axi_tx_tdata  = tdata_q;
  assign m_axi_tx_tkeep  = tkeep_q;
  assign m_axi_tx_tlast  = tlast_q;
  assign m_axi_tx_tvalid = tvalid_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_aurora8b10b_tx_frame_gen.sv
// Directed self-checking bench for aurora8b10b_tx_frame_gen (GAP_CYCLES = 4).
module tb_aurora8b10b_tx_frame_gen;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             up;
  logic             start;
  logic [LEN_W-1:0] flen;
  logic [LEN_W-1:0] fnum;
  logic             stop;
  logic [31:0]      tdata;
  logic [3:0]       tkeep;
  logic             tlast;
  logic             tvalid;
  logic             tready;
  logic             busy;
  logic             done;
  logic [31:0]      fcnt;

  int checks = 0;
  int passes = 0;

  logic [31:0] xd[$];
  logic [3:0]  xk[$];
  logic        xl[$];
  int          xc[$];
  int          done_cnt;

  always #5 clk = ~clk;

  aurora8b10b_tx_frame_gen #(.GAP_CYCLES(4), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_channel_up(up), .i_start(start),
    .i_frame_len(flen), .i_frame_num(fnum), .i_stop(stop),
    .m_axi_tx_tdata(tdata), .m_axi_tx_tkeep(tkeep), .m_axi_tx_tlast(tlast),
    .m_axi_tx_tvalid(tvalid), .m_axi_tx_tready(tready),
    .o_busy(busy), .o_done(done), .o_frame_cnt(fcnt)
  );

  function automatic logic [31:0] exp_data(input int f, input int w);
`ifdef TX_PRBS_EN
    logic [31:0] s;
    s = 32'h7FFF_FFFF;
    for (int k = 0; k <= w; k++)
      for (int b = 0; b < 32; b++) s = {s[30:0], s[30] ^ s[27]};
    return s ^ 32'(f * 0);
`else
    return {f[15:0], w[15:0]};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int len, input int num);
    flen  = LEN_W'(len);
    fnum  = LEN_W'(num);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Records every accepted word until o_done; optionally pulses i_stop once stop_after words are seen.
  task automatic collect(input int maxc, input int stop_after);
    xd.delete(); xk.delete(); xl.delete(); xc.delete();
    done_cnt = 0;
    for (int i = 0; i < maxc && done_cnt == 0; i++) begin
      stop = 1'b0;
      if (tvalid && tready) begin
        xd.push_back(tdata); xk.push_back(tkeep); xl.push_back(tlast); xc.push_back(i);
        if (xd.size() == stop_after) stop = 1'b1;
      end
      if (done) done_cnt++;
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; up = 1'b1; start = 1'b0; flen = '0; fnum = '0; stop = 1'b0; tready = 1'b1;
    repeat (3) step();
    checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tvalid); else passes++;
    checks++; if (tdata !== 32'h0) $display("FAIL reset_tdata: got %h want 00000000", tdata); else passes++;
    checks++; if (tkeep !== 4'h0) $display("FAIL reset_tkeep: got %b want 0000", tkeep); else passes++;
    checks++; if (tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", tlast); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (fcnt !== 32'd0) $display("FAIL reset_frame_cnt: got %0d want 0", fcnt); else passes++;
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_basic();
    start_run(10, 2);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
    collect(100, -1);
    checks++; if (xd.size() != 6) $display("FAIL basic_count: got %0d want 6", xd.size()); else passes++;
    for (int i = 0; i < xd.size() && i < 6; i++) begin
      checks++;
      if (xd[i] !== exp_data(i / 3, i % 3)) $display("FAIL basic_data[%0d]: got %h want %h", i, xd[i], exp_data(i / 3, i % 3));
      else passes++;
      checks++;
      if (xl[i] !== (i % 3 == 2)) $display("FAIL basic_tlast[%0d]: got %b want %b", i, xl[i], (i % 3 == 2));
      else passes++;
      checks++;
      if (xk[i] !== ((i % 3 == 2) ? 4'b1100 : 4'b1111)) $display("FAIL basic_tkeep[%0d]: got %b want %b", i, xk[i], ((i % 3 == 2) ? 4'b1100 : 4'b1111));
      else passes++;
    end
    if (xd.size() >= 4) begin
      checks++; if (xc[1] - xc[0] != 1) $display("FAIL basic_word_rate: got %0d want 1", xc[1] - xc[0]); else passes++;
      checks++; if (xc[3] - xc[2] != 5) $display("FAIL basic_gap: got %0d idle cycles want 4", xc[3] - xc[2] - 1); else passes++;
    end
    checks++; if (done_cnt != 1) $display("FAIL basic_done_seen: got %0d want 1", done_cnt); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL basic_done_one_cycle: got %b want 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else passes++;
    checks++; if (fcnt !== 32'd2) $display("FAIL basic_frame_cnt: got %0d want 2", fcnt); else passes++;
  endtask

  task automatic test_stall();
    logic [31:0] d1;
    logic [3:0]  k1;
    logic        l1;
    logic        pat[4];
    int          nx;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    nx = 0; d1 = '0; k1 = '0; l1 = 1'b0;
    start_run(8, 1);
    for (int i = 0; i < 10 && !tvalid; i++) step();
    checks++; if (tvalid !== 1'b1) $display("FAIL stall_tvalid_timeout: got %b want 1", tvalid); else passes++;
    for (int k = 0; k < 4; k++) begin
      tready = pat[k];
      if (k == 0) begin
        checks++; if (tdata !== exp_data(0, 0)) $display("FAIL stall_word0: got %h want %h", tdata, exp_data(0, 0)); else passes++;
      end else if (k == 1) begin
        d1 = tdata; k1 = tkeep; l1 = tlast;
        checks++; if (tdata !== exp_data(0, 1)) $display("FAIL stall_word1: got %h want %h", tdata, exp_data(0, 1)); else passes++;
      end else begin
        checks++;
        if (tdata !== d1 || tkeep !== k1 || tlast !== l1 || tvalid !== 1'b1)
          $display("FAIL stall_hold[%0d]: got %h/%b/%b/%b want %h/%b/%b/1", k, tdata, tkeep, tlast, tvalid, d1, k1, l1);
        else passes++;
      end
      if (tvalid && tready) nx++;
      step();
    end
    tready = 1'b1;
    checks++; if (k1 !== 4'b1111 || l1 !== 1'b1) $display("FAIL stall_last_word: got keep %b last %b want 1111 1", k1, l1); else passes++;
    for (int i = 0; i < 10 && !done; i++) begin
      if (tvalid) nx++;
      step();
    end
    checks++; if (nx != 2) $display("FAIL stall_transfers: got %0d want 2", nx); else passes++;
    checks++; if (done !== 1'b1) $display("FAIL stall_done_timeout: got %b want 1", done); else passes++;
    step();
    checks++; if (fcnt !== 32'd3) $display("FAIL stall_frame_cnt: got %0d want 3", fcnt); else passes++;
  endtask

  task automatic test_single();
    int lens[2];
    logic [3:0] keeps[2];
    lens[0] = 1; keeps[0] = 4'b1000;
    lens[1] = 4; keeps[1] = 4'b1111;
    for (int t = 0; t < 2; t++) begin
      start_run(lens[t], 1);
      collect(30, -1);
      checks++;
      if (xd.size() != 1) $display("FAIL single_count_len%0d: got %0d want 1", lens[t], xd.size());
      else passes++;
      if (xd.size() >= 1) begin
        checks++;
        if (xd[0] !== exp_data(0, 0) || xl[0] !== 1'b1 || xk[0] !== keeps[t])
          $display("FAIL single_word_len%0d: got %h/%b/%b want %h/1/%b", lens[t], xd[0], xl[0], xk[0], exp_data(0, 0), keeps[t]);
        else passes++;
      end
    end
    checks++; if (fcnt !== 32'd5) $display("FAIL single_frame_cnt: got %0d want 5", fcnt); else passes++;
  endtask

  task automatic test_drop();
    logic low_ok;
    start_run(20, 1);
    for (int i = 0; i < 10 && !tvalid; i++) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_data(0, k)) $display("FAIL drop_pre_word%0d: got %b/%h want 1/%h", k, tvalid, tdata, exp_data(0, k));
      else passes++;
      step();
    end
    checks++; if (tvalid !== 1'b1 || tdata !== exp_data(0, 2)) $display("FAIL drop_word2: got %b/%h want 1/%h", tvalid, tdata, exp_data(0, 2)); else passes++;
    up = 1'b0; tready = 1'b0;
    step();
    checks++; if (tvalid !== 1'b0) $display("FAIL drop_tvalid_next: got %b want 0", tvalid); else passes++;
    low_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (tvalid !== 1'b0) low_ok = 1'b0;
      step();
    end
    checks++; if (low_ok !== 1'b1) $display("FAIL drop_tvalid_low: got %b want 1", low_ok); else passes++;
    checks++; if (fcnt !== 32'd5) $display("FAIL drop_frame_cnt_hold: got %0d want 5", fcnt); else passes++;
    up = 1'b1; tready = 1'b1;
    collect(40, -1);
    checks++; if (xd.size() != 5) $display("FAIL drop_restart_count: got %0d want 5", xd.size()); else passes++;
    for (int i = 0; i < xd.size() && i < 5; i++) begin
      checks++;
      if (xd[i] !== exp_data(0, i)) $display("FAIL drop_restart_data[%0d]: got %h want %h", i, xd[i], exp_data(0, i));
      else passes++;
    end
    checks++; if (fcnt !== 32'd6) $display("FAIL drop_frame_cnt: got %0d want 6", fcnt); else passes++;
  endtask

  task automatic test_stop();
    start_run(8, 0);
    collect(200, 7);
    checks++; if (xd.size() != 8) $display("FAIL stop_count: got %0d want 8", xd.size()); else passes++;
    for (int i = 0; i < xd.size() && i < 8; i++) begin
      checks++;
      if (xd[i] !== exp_data(i / 2, i % 2)) $display("FAIL stop_data[%0d]: got %h want %h", i, xd[i], exp_data(i / 2, i % 2));
      else passes++;
    end
    if (xd.size() == 8) begin
      checks++; if (xl[7] !== 1'b1) $display("FAIL stop_tlast: got %b want 1", xl[7]); else passes++;
    end
    checks++; if (done_cnt != 1) $display("FAIL stop_done: got %0d want 1", done_cnt); else passes++;
    checks++; if (fcnt !== 32'd10) $display("FAIL stop_frame_cnt: got %0d want 10", fcnt); else passes++;
  endtask

  task automatic test_zero_len();
    logic idle_ok;
    start_run(0, 1);
    idle_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || tvalid !== 1'b0) idle_ok = 1'b0;
      step();
    end
    checks++; if (idle_ok !== 1'b1) $display("FAIL zero_len_busy: got %b want 1", idle_ok); else passes++;
    checks++; if (fcnt !== 32'd10) $display("FAIL zero_len_frame_cnt: got %0d want 10", fcnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_drop();
    test_stop();
    test_zero_len();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
